// File: rtl/music_pkg.sv
// Shared definitions for the music recorder and its note RAM.
// Holds the parameter defaults, the note code type and the recorder
// state encoding.
package music_pkg;

  localparam int unsigned DEF_DATA_WIDTH      = 10;
  localparam int unsigned DEF_DEPTH           = 32;
  localparam int unsigned DEF_SAMPLE_INTERVAL = 12_500_000;

  // One-hot note plus octave bits; all-zero means silence.
  typedef logic [DEF_DATA_WIDTH-1:0] note_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    RECORDING = 2'd2,
    DONE      = 2'd3
  } rec_state_t;

endpackage

// File: rtl/music_note_ram.sv
// DEPTH x DATA_WIDTH note storage: one synchronous write port and one
// asynchronous read port (maps to distributed RAM).
// Ports:
//   clk      in  clock
//   i_we     in  write enable
//   i_waddr  in  write address
//   i_wdata  in  write data
//   i_raddr  in  read address
//   o_rdata  out read data (combinational)
module music_note_ram
  import music_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/music_recorder.sv
// Live note recorder with song-slot compatible playback.
// Samples note_in every SAMPLE_INTERVAL clocks into a DEPTH-entry RAM,
// then replays through the read_en/read_rst/data_out/output_ready protocol.
// Optional feature macro: MUSIC_RECORDER_SKIP_SILENCE_EN -- when defined,
// rec_start arms the recorder and capture begins on the first non-zero note.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   rec_start     pulse, begin a new recording
//   rec_stop      pulse, end recording (wins over rec_start)
//   note_in       live note code
//   read_en       playback advance enable (level)
//   read_rst      rewind playback to entry 0
//   data_out      registered playback note
//   output_ready  data_out valid
//   recording     armed or recording
//   full          count == DEPTH
//   count         samples stored
module music_recorder
  import music_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH           = DEF_DEPTH,
  parameter int unsigned SAMPLE_INTERVAL = DEF_SAMPLE_INTERVAL,
  localparam int unsigned AW             = $clog2(DEPTH),
  localparam int unsigned CW             = $clog2(DEPTH) + 1,
  localparam int unsigned SW             = $clog2(SAMPLE_INTERVAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rec_start,
  input  logic                  rec_stop,
  input  logic [DATA_WIDTH-1:0] note_in,
  input  logic                  read_en,
  input  logic                  read_rst,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  output_ready,
  output logic                  recording,
  output logic                  full,
  output logic [CW-1:0]         count
);

  localparam logic [SW-1:0] SI_LAST = SW'(SAMPLE_INTERVAL);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  rec_state_t            r_state, w_state_nxt;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic [CW-1:0]         r_rd_ptr, w_rd_ptr_nxt;
  logic [SW-1:0]         r_wr_cnt, w_wr_cnt_nxt;
  logic [SW-1:0]         r_rd_cnt, w_rd_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data_out, w_data_out_nxt;
  logic                  r_output_ready, w_output_ready_nxt;
  logic                  r_recording, r_full;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rd_data;

  music_note_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_count[AW-1:0]),
    .i_wdata(note_in),
    .i_raddr(r_rd_ptr[AW-1:0]),
    .o_rdata(w_rd_data)
  );

  always_comb begin
    w_state_nxt        = r_state;
    w_count_nxt        = r_count;
    w_rd_ptr_nxt       = r_rd_ptr;
    w_wr_cnt_nxt       = r_wr_cnt;
    w_rd_cnt_nxt       = r_rd_cnt;
    w_data_out_nxt     = r_data_out;
    w_output_ready_nxt = r_output_ready;
    w_we               = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (rec_start && !rec_stop) begin
          w_count_nxt        = '0;
          w_wr_cnt_nxt       = SW'(1);
          w_rd_ptr_nxt       = '0;
          w_rd_cnt_nxt       = SW'(1);
          w_output_ready_nxt = 1'b0;
`ifdef MUSIC_RECORDER_SKIP_SILENCE_EN
          w_state_nxt        = ARMED;
`else
          w_state_nxt        = RECORDING;
`endif
        end else if (read_rst) begin
          w_rd_ptr_nxt       = '0;
          w_rd_cnt_nxt       = SW'(1);
          w_output_ready_nxt = 1'b0;
        end else if (read_en) begin
          if (r_rd_ptr < r_count) begin
            w_output_ready_nxt = 1'b1;
            w_data_out_nxt     = w_rd_data;
            if (r_rd_cnt == SI_LAST) begin
              w_rd_cnt_nxt = SW'(1);
              w_rd_ptr_nxt = r_rd_ptr + CW'(1);
            end else begin
              w_rd_cnt_nxt = r_rd_cnt + SW'(1);
            end
          end else begin
            w_output_ready_nxt = 1'b0;
          end
        end
      end
      ARMED: begin
`ifdef MUSIC_RECORDER_SKIP_SILENCE_EN
        // First audible note lands in entry 0 and restarts the sample grid.
        if (note_in != '0) begin
          w_we         = 1'b1;
          w_count_nxt  = CW'(1);
          w_wr_cnt_nxt = SW'(1);
          w_state_nxt  = RECORDING;
        end
        if (rec_stop) w_state_nxt = DONE;
`else
        w_state_nxt = IDLE;
`endif
      end
      RECORDING: begin
        if (r_wr_cnt == SI_LAST) begin
          w_we         = 1'b1;
          w_count_nxt  = r_count + CW'(1);
          w_wr_cnt_nxt = SW'(1);
        end else begin
          w_wr_cnt_nxt = r_wr_cnt + SW'(1);
        end
        // A write coinciding with rec_stop still completes.
        if (rec_stop || (w_count_nxt == CNT_MAX)) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_rd_ptr       <= '0;
      r_wr_cnt       <= SW'(1);
      r_rd_cnt       <= SW'(1);
      r_data_out     <= '0;
      r_output_ready <= 1'b0;
      r_recording    <= 1'b0;
      r_full         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_wr_cnt       <= w_wr_cnt_nxt;
      r_rd_cnt       <= w_rd_cnt_nxt;
      r_data_out     <= w_data_out_nxt;
      r_output_ready <= w_output_ready_nxt;
      r_recording    <= (w_state_nxt == ARMED) || (w_state_nxt == RECORDING);
      r_full         <= (w_count_nxt == CNT_MAX);
    end
  end

  assign data_out     = r_data_out;
  assign output_ready = r_output_ready;
  assign recording    = r_recording;
  assign full         = r_full;
  assign count        = r_count;

endmodule

// File: tb/tb_music_recorder.sv
// Scoreboard bench for music_recorder (SAMPLE_INTERVAL=4, DEPTH=32).
// Playback notes are queued when stimulus is issued and checked by a
// monitor; status outputs are checked against hand-computed constants.
module tb_music_recorder;
  import music_pkg::*;

  localparam int unsigned DW  = 10;
  localparam int unsigned DEP = 32;
  localparam int unsigned SI  = 4;
  localparam int unsigned CW  = $clog2(DEP) + 1;
`ifdef MUSIC_RECORDER_SKIP_SILENCE_EN
  localparam int FILL_EDGE = 125;
`else
  localparam int FILL_EDGE = 128;
`endif

  logic          clk = 1'b0;
  logic          rst_n, rec_start, rec_stop, read_en, read_rst;
  logic [DW-1:0] note_in, data_out;
  logic          output_ready, recording, full;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  music_recorder #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DEP),
    .SAMPLE_INTERVAL(SI)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rec_start   (rec_start),
    .rec_stop    (rec_stop),
    .note_in     (note_in),
    .read_en     (read_en),
    .read_rst    (read_rst),
    .data_out    (data_out),
    .output_ready(output_ready),
    .recording   (recording),
    .full        (full),
    .count       (count)
  );

  int    n_vec = 0;
  int    n_err = 0;
  note_t exp_q[$];
  logic  en_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input note_t v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // read_en as seen by the DUT on the last edge
  always @(posedge clk) en_q <= read_en;

  always @(negedge clk) begin
    note_t e;
    if (en_q && output_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL playback_extra: got 0x%0h, expected no output", data_out);
      end else begin
        e = exp_q.pop_front();
        check("playback_data", 32'(data_out), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rec_start = 1'b0; rec_stop = 1'b0;
    read_en = 1'b0; read_rst = 1'b0; note_in = '0;

    // Reset
    tick(); tick();
    check("rst_data_out", 32'(data_out), 0);
    check("rst_ready", 32'(output_ready), 0);
    check("rst_recording", 32'(recording), 0);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    rst_n = 1'b1;
    read_en = 1'b1;
    tick(); tick(); tick();
    check("empty_read_ready", 32'(output_ready), 0);
    read_en = 1'b0;

    // Short recording: 004 / 040 / 080
    note_in = 10'h004; rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
    check("short_recording_on", 32'(recording), 1);
    check("short_count0", 32'(count), 0);
    for (int i = 1; i <= 12; i++) begin
      note_in = (i <= 4) ? 10'h004 : (i <= 8) ? 10'h040 : 10'h080;
      read_en = (i >= 5 && i <= 7);
      tick();
      if (i == 3) check("short_count_e3", 32'(count), 0);
      if (i == 4) check("short_count_e4", 32'(count), 1);
      if (i == 6) check("rec_ignores_read", 32'(output_ready), 0);
    end
    read_en = 1'b0;
    note_in = '0; rec_stop = 1'b1;
    tick();
    rec_stop = 1'b0;
    check("short_count", 32'(count), 3);
    check("short_recording_off", 32'(recording), 0);
    check("short_state", 32'(dut.r_state), 32'(DONE));
    check("short_full", 32'(full), 0);

    // Playback
    read_en = 1'b1;
    push_n(10'h004, 4); push_n(10'h040, 4); push_n(10'h080, 4);
    for (int i = 1; i <= 12; i++) tick();
    check("play_ready_e12", 32'(output_ready), 1);
    tick();
    check("play_ready_e13", 32'(output_ready), 0);
    read_en = 1'b0; read_rst = 1'b1;
    tick();
    read_rst = 1'b0;
    check("rewind_ready", 32'(output_ready), 0);
    read_en = 1'b1;
    push_n(10'h004, 4);
    for (int i = 1; i <= 4; i++) tick();
    read_en = 1'b0;

    // rec_start with rec_stop in DONE
    rec_start = 1'b1; rec_stop = 1'b1;
    tick();
    rec_start = 1'b0; rec_stop = 1'b0;
    check("startstop_state", 32'(dut.r_state), 32'(DONE));
    check("startstop_count", 32'(count), 3);
    check("startstop_recording", 32'(recording), 0);

    // Leading silence
    note_in = '0; rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
`ifdef MUSIC_RECORDER_SKIP_SILENCE_EN
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("armed_count", 32'(count), 0);
    end
    check("armed_recording", 32'(recording), 1);
    note_in = 10'h040;
    tick();
    check("armed_first_count", 32'(count), 1);
    check("armed_first_state", 32'(dut.r_state), 32'(RECORDING));
    rec_stop = 1'b1;
    tick();
    rec_stop = 1'b0;
    check("armed_stop_count", 32'(count), 1);
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3) check("silence_count_e3", 32'(count), 0);
      if (i == 4) check("silence_count_e4", 32'(count), 1);
    end
    check("silence_count_e20", 32'(count), 5);
    rec_stop = 1'b1;
    tick();
    rec_stop = 1'b0;
    check("silence_stop_count", 32'(count), 5);
`endif
    check("silence_state", 32'(dut.r_state), 32'(DONE));

    // Fill
    note_in = 10'h020; rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
    for (int e = 1; e <= 140; e++) begin
      tick();
      if (e == FILL_EDGE - 1) begin
        check("fill_count_pre", 32'(count), 31);
        check("fill_full_pre", 32'(full), 0);
      end
      if (e == FILL_EDGE) begin
        check("fill_count", 32'(count), 32);
        check("fill_full", 32'(full), 1);
        check("fill_state", 32'(dut.r_state), 32'(DONE));
        check("fill_recording", 32'(recording), 0);
      end
    end
    check("fill_count_hold", 32'(count), 32);
    read_rst = 1'b1;
    tick();
    read_rst = 1'b0;
    read_en = 1'b1;
    push_n(10'h020, 128);
    for (int i = 1; i <= 128; i++) tick();
    check("fill_play_ready_last", 32'(output_ready), 1);
    tick();
    check("fill_play_ready_end", 32'(output_ready), 0);
    read_en = 1'b0;

    // Reset mid-recording
    note_in = 10'h100; rec_start = 1'b1;
    tick();
    rec_start = 1'b0;
    for (int i = 0; i < 100 && count != CW'(7); i++) tick();
    check("midrst_reach7", 32'(count), 7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_count", 32'(count), 0);
    check("midrst_recording", 32'(recording), 0);
    check("midrst_state", 32'(dut.r_state), 32'(IDLE));
    check("midrst_full", 32'(full), 0);

    tick(); tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
